// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, Imem address and decode fetch queue
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data,
  input  logic        imem_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  localparam int          PW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, HALT} state_t;

  state_t          state, state_next;
  logic [31:0]     pc;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            enq, deq;

  logic [31:0]     q_pc    [FIFO_DEPTH];
  logic [31:0]     q_instr [FIFO_DEPTH];
  logic            q_fault [FIFO_DEPTH];

  // Values of the most recently popped entry, shown while the queue is empty.
  logic [31:0]     last_pc, last_instr;
  logic            last_fault;

  // Next state plus enqueue/dequeue strobes; a redirect overrides everything.
  always_comb begin
    state_next = state;
    enq        = 1'b0;
    deq        = 1'b0;
    if (redirect_valid) begin
      state_next = RUN;
    end else begin
      // Fullness is judged before this cycle's pop, so there is no bypass.
      enq = (state == RUN) && (count < CW'(FIFO_DEPTH));
      deq = out_valid && out_ready;
      if (enq && !imem_valid) state_next = HALT;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  // PC, queue pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq && imem_valid) pc <= pc + 32'd4;
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // Queue storage; faulting fetches are stored as a NOP with the fault flag set.
  always_ff @(posedge clock) begin
    if (enq) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= imem_valid ? imem_data : NOP;
      q_fault[wr_ptr] <= !imem_valid;
    end
  end

  // Remember each popped entry so outputs hold steady once the queue drains.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_pc    <= '0;
      last_instr <= '0;
      last_fault <= 1'b0;
    end else if (deq) begin
      last_pc    <= q_pc[rd_ptr];
      last_instr <= q_instr[rd_ptr];
      last_fault <= q_fault[rd_ptr];
    end
  end

  assign imem_address = pc;
  assign out_valid    = (count != '0);
  assign out_pc       = out_valid ? q_pc[rd_ptr]    : last_pc;
  assign out_instr    = out_valid ? q_instr[rd_ptr] : last_instr;
  assign out_fault    = out_valid ? q_fault[rd_ptr] : last_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset, reset2;
  logic [31:0] imem_address, imem_data, imem_address2, imem_data2;
  logic        imem_valid, imem_valid2;
  logic        redirect_valid, redirect_valid2;
  logic [31:0] redirect_pc, redirect_pc2;
  logic        out_valid, out_ready, out_fault, out_valid2, out_ready2, out_fault2;
  logic [31:0] out_pc, out_instr, out_pc2, out_instr2;
  logic [31:0] stop_addr, stop_addr2;

  int n_cmp = 0;
  int n_bad = 0;
  ent_t sb[$];
  ent_t sb2[$];

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock(clock), .reset(reset),
    .imem_address(imem_address), .imem_data(imem_data), .imem_valid(imem_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut2 (
    .clock(clock), .reset(reset2),
    .imem_address(imem_address2), .imem_data(imem_data2), .imem_valid(imem_valid2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_pc(out_pc2), .out_instr(out_instr2), .out_fault(out_fault2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic ent_t mk(input logic [31:0] pc, input logic fault);
    ent_t e;
    e.pc    = pc;
    e.fault = fault;
    e.instr = fault ? 32'h0000_0013 : mem_word(pc);
    return e;
  endfunction

  // Imem model: aligned addresses answer, except the per-test stop address.
  always_comb begin
    imem_data   = mem_word(imem_address);
    imem_valid  = (imem_address[1:0] == 2'b00) && (imem_address != stop_addr);
    imem_data2  = mem_word(imem_address2);
    imem_valid2 = (imem_address2[1:0] == 2'b00) && (imem_address2 != stop_addr2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pop the scoreboard on every accepted handshake (redirect discards it).
  always @(negedge clock) begin
    if (reset && out_valid && out_ready && !redirect_valid) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        ent_t e;
        e = sb.pop_front();
        check("out_pc", out_pc, e.pc);
        check("out_instr", out_instr, e.instr);
        check("out_fault", 32'(out_fault), 32'(e.fault));
      end
    end
    if (reset2 && out_valid2 && out_ready2 && !redirect_valid2) begin
      check("sb2_has_entry", 32'(sb2.size() != 0), 32'd1);
      if (sb2.size() != 0) begin
        ent_t e;
        e = sb2.pop_front();
        check("out_pc2", out_pc2, e.pc);
        check("out_instr2", out_instr2, e.instr);
        check("out_fault2", 32'(out_fault2), 32'(e.fault));
      end
    end
  end

  task automatic wait_drain(input string tag, input int which);
    for (int i = 0; i < 40; i++) begin
      if ((which == 1 ? sb.size() : sb2.size()) == 0) break;
      @(negedge clock);
    end
    check(tag, (which == 1) ? sb.size() : sb2.size(), 0);
  endtask

  task automatic wait_addr(input string tag, input logic [31:0] a);
    for (int i = 0; i < 20; i++) begin
      if (imem_address == a) break;
      tick();
    end
    check(tag, imem_address, a);
  endtask

  initial begin
    reset = 1'b0; reset2 = 1'b0;
    out_ready = 1'b1; out_ready2 = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    redirect_valid2 = 1'b0; redirect_pc2 = '0;
    stop_addr = 32'h10; stop_addr2 = 32'h4;
    repeat (2) tick();

    check("rst_valid", 32'(out_valid), 0);
    check("rst_addr", imem_address, 32'h0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instr, 0);
    check("rst_fault", 32'(out_fault), 0);

    // Streaming after reset release, ending in a fault at the stop address.
    for (int i = 0; i < 4; i++) sb.push_back(mk(32'(i * 4), 1'b0));
    sb.push_back(mk(32'h10, 1'b1));
    reset = 1'b1;
    @(negedge clock);
    check("t1_valid_release", 32'(out_valid), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t1_valid_stream", 32'(out_valid), 1);
    end
    @(negedge clock);
    check("t1_idle", 32'(out_valid), 0);
    check("t1_halt_addr", imem_address, 32'h10);
    check("t1_drain", sb.size(), 0);

    // Back-pressure: queue fills, head holds, then drains in order.
    tick(); reset = 1'b0; out_ready = 1'b0;
    tick(); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i > 0) check("t2_hold_pc", out_pc, 32'h0);
    end
    check("t2_addr_full", imem_address, 32'h8);
    check("t2_valid", 32'(out_valid), 1);
    check("t2_head_instr", out_instr, mem_word(32'h0));
    for (int i = 0; i < 4; i++) sb.push_back(mk(32'(i * 4), 1'b0));
    sb.push_back(mk(32'h10, 1'b1));
    out_ready = 1'b1;
    wait_drain("t2_drain", 1);
    tick();
    check("t2_idle", 32'(out_valid), 0);

    // Redirect while full, with a same-cycle handshake that must be discarded.
    tick(); reset = 1'b0; out_ready = 1'b0; stop_addr = 32'h110;
    tick(); reset = 1'b1;
    repeat (3) tick();
    check("t3_full_addr", imem_address, 32'h8);
    check("t3_full_valid", 32'(out_valid), 1);
    for (int i = 0; i < 4; i++) sb.push_back(mk(32'h100 + 32'(i * 4), 1'b0));
    sb.push_back(mk(32'h110, 1'b1));
    redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t3_flush_valid", 32'(out_valid), 0);
    check("t3_flush_addr", imem_address, 32'h100);
    wait_drain("t3_drain", 1);
    tick();
    check("t3_idle", 32'(out_valid), 0);

    // Misaligned redirect out of HALT gives a single fault entry.
    sb.push_back(mk(32'h102, 1'b1));
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    wait_drain("t4_drain", 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_pc_frozen", imem_address, 32'h102);
      check("t4_no_enq", 32'(out_valid), 0);
    end

    // Asynchronous reset with two entries queued.
    stop_addr = 32'h220; out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    wait_addr("t6_reach_full", 32'h208);
    check("t6_queued", 32'(out_valid), 1);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 0);
    check("t6_async_addr", imem_address, 32'h0);
    check("t6_async_pc", out_pc, 32'h0);
    sb.delete();
    stop_addr = 32'h8;
    sb.push_back(mk(32'h0, 1'b0));
    sb.push_back(mk(32'h4, 1'b0));
    sb.push_back(mk(32'h8, 1'b1));
    out_ready = 1'b1;
    tick(); reset = 1'b1;
    wait_drain("t6_drain", 1);
    tick();
    check("t6_idle", 32'(out_valid), 0);

    // PC wrap from the top of the address space on the second instance.
    check("t5_rst_addr", imem_address2, 32'hFFFF_FFF8);
    sb2.push_back(mk(32'hFFFF_FFF8, 1'b0));
    sb2.push_back(mk(32'hFFFF_FFFC, 1'b0));
    sb2.push_back(mk(32'h0000_0000, 1'b0));
    sb2.push_back(mk(32'h0000_0004, 1'b1));
    reset2 = 1'b1;
    wait_drain("t5_drain", 2);
    tick();
    check("t5_idle", 32'(out_valid2), 0);
    check("t5_halt_addr", imem_address2, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
